// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and widths for the MEM-stage data-memory access controller.
// Revision: 1.0
`default_nettype none

package dmem_access_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_timeout_cnt.sv
// Clearable cycle counter that raises expire once it has counted TIMEOUT-1 cycles.
// Revision: 1.0
`default_nettype none

module dmem_timeout_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] count;

    assign expire = (count == W'(TIMEOUT - 1));

    // Holds at the limit so a lingering enable can never wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
// Sequences MEM-stage loads/stores against a variable-latency data memory,
// stalling the pipeline and bubbling WB until the access retires.
// Revision: 1.0
`default_nettype none

import dmem_access_ctrl_pkg::*;

module dmem_access_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    output logic              wb_bubble,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t state, state_nx;
    logic   acc;
    logic   to_clear;
    logic   to_en;
    logic   to_expire;
    logic   abandon;

    assign acc   = mem_r_en | mem_w_en;
    assign to_en = (state == REQ) || (state == RESP);

    // Completion in the expiry cycle wins over abandonment.
    assign abandon = to_expire &&
                     (((state == REQ)  && !dm_gnt) ||
                      ((state == RESP) && !dm_rvalid));

    dmem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (to_clear),
        .enable (to_en),
        .expire (to_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        wb_bubble = 1'b0;
        dm_req    = 1'b0;
        to_clear  = 1'b0;
        case (state)
            IDLE: begin
                stall     = acc;
                wb_bubble = acc;
                if (acc) begin
                    to_clear = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                dm_req    = 1'b1;
                stall     = 1'b1;
                wb_bubble = 1'b1;
                if (dm_gnt) begin
                    state_nx = dm_we ? DONE : RESP;
                end else if (to_expire) begin
                    state_nx = DONE;
                end
            end
            RESP: begin
                stall     = 1'b1;
                wb_bubble = 1'b1;
                if (dm_rvalid || to_expire) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_we       <= 1'b0;
            dm_addr     <= '0;
            dm_wdata    <= '0;
            rd_data     <= '0;
            timeout_err <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if ((state == IDLE) && acc) begin
                dm_we    <= ~mem_r_en;
                dm_addr  <= addr_in;
                dm_wdata <= wdata_in;
            end
            if (abandon) begin
                rd_data     <= '0;
                timeout_err <= 1'b1;
            end else if ((state == RESP) && dm_rvalid) begin
                rd_data <= dm_rdata;
            end
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl (default and TIMEOUT=4 instances).
// Revision: 1.0
`default_nettype none

module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst;
    int          n_tests;
    int          n_fail;

    // Main instance, default TIMEOUT
    logic        mem_r_en, mem_w_en, dm_gnt, dm_rvalid;
    logic [31:0] addr_in, wdata_in, dm_rdata;
    logic        dm_req, dm_we, stall, wb_bubble, timeout_err;
    logic [31:0] dm_addr, dm_wdata, rd_data;
    logic [15:0] stall_cnt;

    // Short-timeout instance
    logic        t_r_en, t_w_en, t_gnt, t_rvalid;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic        t_dm_req, t_dm_we, t_stall, t_wb_bubble, t_err;
    logic [31:0] t_dm_addr, t_dm_wdata, t_rd_data;
    logic [15:0] t_stall_cnt;

    dmem_access_ctrl #(.TIMEOUT(64), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .addr_in(addr_in), .wdata_in(wdata_in), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .rd_data(rd_data), .stall(stall), .wb_bubble(wb_bubble),
        .timeout_err(timeout_err), .stall_cnt(stall_cnt)
    );

    dmem_access_ctrl #(.TIMEOUT(4), .CNT_W(16)) u_to (
        .clk(clk), .rst(rst), .mem_r_en(t_r_en), .mem_w_en(t_w_en),
        .addr_in(t_addr), .wdata_in(t_wdata), .dm_req(t_dm_req), .dm_we(t_dm_we),
        .dm_addr(t_dm_addr), .dm_wdata(t_dm_wdata), .dm_gnt(t_gnt), .dm_rvalid(t_rvalid),
        .dm_rdata(t_rdata), .rd_data(t_rd_data), .stall(t_stall), .wb_bubble(t_wb_bubble),
        .timeout_err(t_err), .stall_cnt(t_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        mem_r_en = 0; mem_w_en = 0; dm_gnt = 0; dm_rvalid = 0;
        addr_in = 0; wdata_in = 0; dm_rdata = 0;
        t_r_en = 0; t_w_en = 0; t_gnt = 0; t_rvalid = 0;
        t_addr = 0; t_wdata = 0; t_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL rst_dm_req got=%b exp=0", dm_req); end
        n_tests++; if (stall !== 1'b0 || wb_bubble !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b%b exp=00", stall, wb_bubble); end
        n_tests++; if (dm_addr !== 32'h0 || dm_wdata !== 32'h0 || dm_we !== 1'b0) begin n_fail++; $display("FAIL rst_regs addr=%h wdata=%h we=%b exp=0", dm_addr, dm_wdata, dm_we); end
        n_tests++; if (rd_data !== 32'h0 || timeout_err !== 1'b0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_status rd=%h err=%b cnt=%0d exp=0", rd_data, timeout_err, stall_cnt); end
    endtask

    task automatic test_store();
        do_reset();
        @(negedge clk);
        mem_w_en = 1; addr_in = 32'h40; wdata_in = 32'hA5A5_0001;
        #1;
        n_tests++; if (stall !== 1'b1 || wb_bubble !== 1'b1 || dm_req !== 1'b0) begin n_fail++; $display("FAIL st_detect stall=%b bub=%b req=%b exp=110", stall, wb_bubble, dm_req); end
        @(negedge clk);
        n_tests++; if (dm_req !== 1'b1 || dm_we !== 1'b1) begin n_fail++; $display("FAIL st_req req=%b we=%b exp=11", dm_req, dm_we); end
        n_tests++; if (dm_addr !== 32'h40 || dm_wdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL st_addr addr=%h wdata=%h exp=40 a5a50001", dm_addr, dm_wdata); end
        dm_gnt = 1;
        @(negedge clk);
        n_tests++; if (stall !== 1'b0 || wb_bubble !== 1'b0 || dm_req !== 1'b0) begin n_fail++; $display("FAIL st_done stall=%b bub=%b req=%b exp=000", stall, wb_bubble, dm_req); end
        n_tests++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL st_cnt got=%0d exp=2", stall_cnt); end
        mem_w_en = 0; dm_gnt = 0;
        @(negedge clk);
        n_tests++; if (stall !== 1'b0 || dm_req !== 1'b0 || stall_cnt !== 16'd2) begin n_fail++; $display("FAIL st_idle stall=%b req=%b cnt=%0d exp=0 0 2", stall, dm_req, stall_cnt); end
    endtask

    task automatic test_load();
        do_reset();
        @(negedge clk);
        mem_r_en = 1; addr_in = 32'h80;
        #1;
        n_tests++; if (wb_bubble !== 1'b1) begin n_fail++; $display("FAIL ld_bub_detect got=%b exp=1", wb_bubble); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (dm_req !== 1'b1 || wb_bubble !== 1'b1 || dm_we !== 1'b0) begin n_fail++; $display("FAIL ld_req%0d req=%b bub=%b we=%b exp=110", i, dm_req, wb_bubble, dm_we); end
            if (i == 2) begin
                dm_gnt = 1; dm_rvalid = 1; dm_rdata = 32'hDEAD_BEEF;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dm_gnt = 0; dm_rvalid = 0;
            n_tests++; if (dm_req !== 1'b0 || stall !== 1'b1 || wb_bubble !== 1'b1) begin n_fail++; $display("FAIL ld_resp%0d req=%b stall=%b bub=%b exp=011", i, dm_req, stall, wb_bubble); end
            if (i == 2) begin
                dm_rvalid = 1; dm_rdata = 32'h1234_5678;
            end
        end
        @(negedge clk);
        dm_rvalid = 0;
        n_tests++; if (rd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL ld_data got=%h exp=12345678", rd_data); end
        n_tests++; if (stall !== 1'b0 || wb_bubble !== 1'b0) begin n_fail++; $display("FAIL ld_done stall=%b bub=%b exp=00", stall, wb_bubble); end
        n_tests++; if (stall_cnt !== 16'd7) begin n_fail++; $display("FAIL ld_cnt got=%0d exp=7", stall_cnt); end
        mem_r_en = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        mem_r_en = 1; addr_in = 32'h90;
        @(negedge clk);
        dm_gnt = 1;
        @(negedge clk);
        dm_gnt = 0; dm_rvalid = 1; dm_rdata = 32'h0000_0777;
        @(negedge clk);
        dm_rvalid = 0;
        n_tests++; if (stall !== 1'b0 || dm_req !== 1'b0 || rd_data !== 32'h777) begin n_fail++; $display("FAIL b2b_done1 stall=%b req=%b rd=%h exp=0 0 777", stall, dm_req, rd_data); end
        mem_r_en = 0; mem_w_en = 1; addr_in = 32'h94; wdata_in = 32'h0000_0999;
        @(negedge clk);
        n_tests++; if (stall !== 1'b1 || dm_req !== 1'b0) begin n_fail++; $display("FAIL b2b_detect stall=%b req=%b exp=10", stall, dm_req); end
        @(negedge clk);
        n_tests++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_addr !== 32'h94 || dm_wdata !== 32'h999) begin n_fail++; $display("FAIL b2b_req2 req=%b we=%b addr=%h wd=%h exp=1 1 94 999", dm_req, dm_we, dm_addr, dm_wdata); end
        dm_gnt = 1;
        @(negedge clk);
        n_tests++; if (stall !== 1'b0 || dm_req !== 1'b0) begin n_fail++; $display("FAIL b2b_done2 stall=%b req=%b exp=00", stall, dm_req); end
        mem_w_en = 0; dm_gnt = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk);
        t_r_en = 1; t_addr = 32'h100;
        @(negedge clk);
        t_gnt = 1;
        @(negedge clk);
        t_gnt = 0; t_rvalid = 1; t_rdata = 32'hCAFE_0001;
        @(negedge clk);
        t_rvalid = 0; t_r_en = 0;
        n_tests++; if (t_rd_data !== 32'hCAFE_0001 || t_err !== 1'b0) begin n_fail++; $display("FAIL to_first_load rd=%h err=%b exp=cafe0001 0", t_rd_data, t_err); end
        @(negedge clk);
        t_r_en = 1; t_addr = 32'h104;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++; if (t_dm_req !== 1'b1 || t_err !== 1'b0 || t_stall !== 1'b1) begin n_fail++; $display("FAIL to_req%0d req=%b err=%b stall=%b exp=101", i, t_dm_req, t_err, t_stall); end
        end
        @(negedge clk);
        n_tests++; if (t_err !== 1'b1) begin n_fail++; $display("FAIL to_err got=%b exp=1", t_err); end
        n_tests++; if (t_rd_data !== 32'h0) begin n_fail++; $display("FAIL to_rd_zero got=%h exp=0", t_rd_data); end
        n_tests++; if (t_stall !== 1'b0 || t_wb_bubble !== 1'b0 || t_dm_req !== 1'b0) begin n_fail++; $display("FAIL to_release stall=%b bub=%b req=%b exp=000", t_stall, t_wb_bubble, t_dm_req); end
        t_r_en = 0; t_gnt = 1;
        @(negedge clk);
        n_tests++; if (t_dm_req !== 1'b0 || t_stall !== 1'b0) begin n_fail++; $display("FAIL to_late_gnt req=%b stall=%b exp=00", t_dm_req, t_stall); end
        t_gnt = 0; t_w_en = 1; t_addr = 32'h108; t_wdata = 32'h0000_00AB;
        @(negedge clk);
        n_tests++; if (t_dm_req !== 1'b1 || t_dm_we !== 1'b1 || t_dm_addr !== 32'h108) begin n_fail++; $display("FAIL to_next_req req=%b we=%b addr=%h exp=1 1 108", t_dm_req, t_dm_we, t_dm_addr); end
        t_gnt = 1;
        @(negedge clk);
        n_tests++; if (t_stall !== 1'b0 || t_err !== 1'b1) begin n_fail++; $display("FAIL to_next_done stall=%b err=%b exp=0 1", t_stall, t_err); end
        t_w_en = 0; t_gnt = 0;
        @(negedge clk);
    endtask

    task automatic test_both_en();
        @(negedge clk);
        mem_r_en = 1; mem_w_en = 1; addr_in = 32'hC0; wdata_in = 32'hFFFF_0000;
        @(negedge clk);
        n_tests++; if (dm_req !== 1'b1 || dm_we !== 1'b0) begin n_fail++; $display("FAIL both_req req=%b we=%b exp=10", dm_req, dm_we); end
        dm_gnt = 1;
        @(negedge clk);
        dm_gnt = 0;
        n_tests++; if (stall !== 1'b1 || dm_req !== 1'b0) begin n_fail++; $display("FAIL both_resp stall=%b req=%b exp=10", stall, dm_req); end
        dm_rvalid = 1; dm_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        dm_rvalid = 0;
        n_tests++; if (rd_data !== 32'h0BAD_F00D || timeout_err !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL both_done rd=%h err=%b stall=%b exp=0badf00d 0 0", rd_data, timeout_err, stall); end
        mem_r_en = 0; mem_w_en = 0;
        @(negedge clk);
    endtask

    task automatic test_rst_mid_access();
        @(negedge clk);
        mem_r_en = 1; addr_in = 32'h200;
        @(negedge clk);
        dm_gnt = 1;
        @(negedge clk);
        dm_gnt = 0;
        n_tests++; if (stall !== 1'b1 || dm_req !== 1'b0) begin n_fail++; $display("FAIL rm_resp stall=%b req=%b exp=10", stall, dm_req); end
        #2;
        rst = 1; mem_r_en = 0;
        #1;
        n_tests++; if (dm_req !== 1'b0 || stall !== 1'b0 || wb_bubble !== 1'b0) begin n_fail++; $display("FAIL rm_async req=%b stall=%b bub=%b exp=000", dm_req, stall, wb_bubble); end
        n_tests++; if (dm_addr !== 32'h0 || dm_we !== 1'b0 || rd_data !== 32'h0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_regs addr=%h we=%b rd=%h cnt=%0d exp=0", dm_addr, dm_we, rd_data, stall_cnt); end
        n_tests++; if (t_err !== 1'b0) begin n_fail++; $display("FAIL rm_err_clear got=%b exp=0", t_err); end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        mem_r_en = 1; addr_in = 32'h300;
        @(negedge clk);
        n_tests++; if (dm_req !== 1'b1 || dm_addr !== 32'h300) begin n_fail++; $display("FAIL rm_new_req req=%b addr=%h exp=1 300", dm_req, dm_addr); end
        dm_gnt = 1;
        @(negedge clk);
        dm_gnt = 0; dm_rvalid = 1; dm_rdata = 32'h5555_AAAA;
        @(negedge clk);
        dm_rvalid = 0; mem_r_en = 0;
        n_tests++; if (rd_data !== 32'h5555_AAAA || stall !== 1'b0 || stall_cnt !== 16'd3) begin n_fail++; $display("FAIL rm_new_done rd=%h stall=%b cnt=%0d exp=5555aaaa 0 3", rd_data, stall, stall_cnt); end
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        clear_inputs();
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
        test_timeout();
        test_both_en();
        test_rst_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences data-memory accesses of the MEM stage against a variable-latency data memory (request/grant, then read-valid).
- Freezes the upstream pipeline with stall while an access is outstanding.
- Forces a bubble into the MEM/WB register via wb_bubble, so WB never commits a load before its data has returned.
- Presents the captured load data to the MEM/WB register in the release cycle; also keeps a sticky timeout error and a stall-cycle performance counter.

Parameters:
- TIMEOUT, 64, cycles in REQ+RESP before the access is abandoned; minimum 2.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_r_en  in  1  EX/MEM load request, held stable while stall=1
- mem_w_en  in  1  EX/MEM store request, held stable while stall=1
- addr_in  in  32  EX/MEM ALU result (byte address)
- wdata_in  in  32  EX/MEM store data
- dm_req  out  1  memory request
- dm_we  out  1  1=write, 0=read; valid with dm_req
- dm_addr  out  32  registered address
- dm_wdata  out  32  registered store data
- dm_gnt  in  1  memory accepted request this cycle
- dm_rvalid  in  1  read data valid this cycle
- dm_rdata  in  32  read data
- rd_data  out  32  captured load data, fed to the MEM/WB memReadIn input
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- wb_bubble  out  1  zero the WB control into MEM/WB
- timeout_err  out  1  sticky, cleared only by rst
- stall_cnt  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE. Reset state IDLE.
- Reset values: dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, rd_data=0, timeout_err=0, stall_cnt=0, timeout counter=0.
- Access definition: acc = mem_r_en | mem_w_en.
  - Both asserted: treated as a read; the write is dropped; no error raised.
- IDLE:
  - stall = acc and wb_bubble = acc, both combinational, so they are high in the detect cycle.
  - On acc: latch addr_in and wdata_in; dm_we <= ~mem_r_en; go to REQ.
- REQ:
  - dm_req=1; stall=1; wb_bubble=1.
  - On dm_gnt: write goes to DONE; read goes to RESP.
- RESP:
  - dm_req=0; stall=1; wb_bubble=1.
  - On dm_rvalid: rd_data <= dm_rdata; go to DONE.
  - dm_rvalid outside RESP is ignored.
  - dm_gnt and dm_rvalid in the same cycle while in REQ: only the grant is consumed; rvalid must arrive later.
- DONE:
  - stall=0, wb_bubble=0 for exactly one cycle.
  - The pipeline advances; MEM/WB captures the real WB control, ALU result and rd_data.
  - Next state is IDLE unconditionally, so the retiring access cannot re-trigger.
  - A back-to-back access is detected in the following IDLE cycle.
- Latency:
  - Minimum stall is 2 cycles (detect, REQ with immediate grant) for a store.
  - Minimum stall is 3 cycles for a load whose rvalid arrives the cycle after the grant.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT-1 without completion: set timeout_err, rd_data <= 0, go to DONE.
  - Late grant or rvalid arriving after abandonment is ignored.
- stall_cnt: increments each cycle stall=1; saturates at all-ones; no wrap.
- Asynchronous reset mid-access returns to IDLE immediately; dm_req drops in the same cycle as rst rises.

Decomposition:
- Shared package: state encoding enum (IDLE=0, REQ=1, RESP=2, DONE=3), DATA_W=32, ADDR_W=32.
- Natural sub-module: dmem_timeout_cnt (clear, enable, expire output), also reusable for instruction-memory fetch.

Test Plan:
- Store, addr=0x40, wdata=0xA5A5_0001, gnt on the first REQ cycle -> dm_req high 1 cycle, dm_we=1, stall high 2 cycles, DONE releases, stall_cnt=2.
- Load, addr=0x80, gnt after 2 REQ cycles, rvalid 3 cycles later with 0x1234_5678 -> rd_data=0x1234_5678 in DONE, wb_bubble high every stalled cycle, stall_cnt=7.
- Back-to-back load then store -> exactly one DONE cycle between them; second dm_req rises 2 cycles after the first DONE.
- No grant, TIMEOUT=4 -> timeout_err=1 after 4 REQ cycles, rd_data=0, pipeline released; later dm_gnt ignored; the next access still completes normally.
- mem_r_en=mem_w_en=1 -> dm_we=0 read issued, no error.
- rst pulsed during RESP -> dm_req=0, stall=0, all outputs at reset values asynchronously; a new load afterwards completes correctly.
